// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: response owner, tag record
// and the kill helper used by the tag pipe.
package mem_arb_pkg;

    localparam int BE_W = 4;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } tag_t;

    // A redirect invalidates fetch responses only; load responses always survive.
    function automatic tag_t kill_tag(input tag_t t, input logic kill);
        tag_t r;
        r = t;
        if (kill && (t.owner == OWN_I)) begin
            r.valid = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// MEM_LAT-deep shift register of {valid, owner} tags tracking in-flight reads,
// with same-cycle invalidation of fetch entries on kill (tail included).
module mem_arb_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t push_i,
    input  logic kill_i,
    output tag_t tail_o
);

    tag_t [MEM_LAT-1:0] pipe_q;
    tag_t [MEM_LAT-1:0] pipe_d;

    // The entry pushed in a kill cycle is the post-redirect fetch, so it is never killed.
    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = push_i;
        for (int k = 1; k < MEM_LAT; k++) begin
            pipe_d[k] = kill_tag(pipe_q[k-1], kill_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tail_o = kill_tag(pipe_q[MEM_LAT-1], kill_i);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch (I) and load/store (D) onto one pipelined memory port and
// routes read data back by owner. Optional fetch starvation guard: MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              I_Req,
    input  logic [ADDR_W-1:0] I_Addr,
    input  logic              I_Kill,
    output logic              I_Gnt,
    output logic              I_RValid,
    output logic [DATA_W-1:0] I_RData,
    input  logic              D_Req,
    input  logic              D_WE,
    input  logic [BE_W-1:0]   D_BE,
    input  logic [ADDR_W-1:0] D_Addr,
    input  logic [DATA_W-1:0] D_WData,
    output logic              D_Gnt,
    output logic              D_RValid,
    output logic [DATA_W-1:0] D_RData,
    output logic              Mem_En,
    output logic              Mem_WE,
    output logic [BE_W-1:0]   Mem_BE,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_WData,
    input  logic [DATA_W-1:0] Mem_RData
);

    if (MEM_LAT < 1 || STARVE_MAX < 1) begin : g_bad_param
        $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must be >= 1");
    end

    logic force_i;
    tag_t push;
    tag_t tail;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;

    assign force_i = (starve_q >= CNT_W'(STARVE_MAX));

    always_comb begin
        starve_d = starve_q;
        if (I_Gnt) begin
            starve_d = '0;
        end else if (I_Req && (starve_q < CNT_W'(STARVE_MAX))) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_i = 1'b0;
`endif

    // Grants are combinational but gated by reset so nothing is accepted while RST is low.
    assign D_Gnt = RST & D_Req & ~(I_Req & force_i);
    assign I_Gnt = RST & I_Req & (~D_Req | force_i);

    assign Mem_En    = I_Gnt | D_Gnt;
    assign Mem_WE    = D_Gnt & D_WE;
    assign Mem_BE    = D_Gnt ? D_BE : (I_Gnt ? {BE_W{1'b1}} : '0);
    assign Mem_Addr  = D_Gnt ? D_Addr : (I_Gnt ? I_Addr : '0);
    assign Mem_WData = D_Gnt ? D_WData : '0;

    // Stores finish at grant; only reads occupy a tag slot.
    assign push.valid = Mem_En & ~Mem_WE;
    assign push.owner = D_Gnt ? OWN_D : OWN_I;

    mem_arb_tag_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_tag_pipe (
        .clk    (CLK),
        .rst_n  (RST),
        .push_i (push),
        .kill_i (I_Kill),
        .tail_o (tail)
    );

    assign I_RValid = tail.valid & (tail.owner == OWN_I);
    assign D_RValid = tail.valid & (tail.owner == OWN_D);
    assign I_RData  = RST ? Mem_RData : '0;
    assign D_RData  = RST ? Mem_RData : '0;

endmodule
